// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg: shared state encoding, Gray successor constants and default widths
// for the quadrature decoder.
`default_nettype none

package quad_decoder_pkg;

  localparam int unsigned DEF_COUNT_W = 32;
  localparam int unsigned DEF_ERR_W   = 16;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Forward successor of each {A,B} value: 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] C_FWD_AFTER_00 = 2'b10;
  localparam logic [1:0] C_FWD_AFTER_10 = 2'b11;
  localparam logic [1:0] C_FWD_AFTER_11 = 2'b01;
  localparam logic [1:0] C_FWD_AFTER_01 = 2'b00;

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = C_FWD_AFTER_00;
      2'b10:   nxt = C_FWD_AFTER_10;
      2'b11:   nxt = C_FWD_AFTER_11;
      default: nxt = C_FWD_AFTER_01;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      C_FWD_AFTER_00: nxt = 2'b00;
      C_FWD_AFTER_10: nxt = 2'b10;
      C_FWD_AFTER_11: nxt = 2'b11;
      default:        nxt = 2'b01;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: unsigned event counter adding 0..2 per cycle, saturating at all-ones,
// with a synchronous clear taking priority over the increment.
`default_nettype none

module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [1:0]       inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_sum = {1'b0, count_q} + {{(WIDTH-1){1'b0}}, inc_i};
    if (clear_i) begin
      count_d = '0;
    end else if (w_sum > {1'b0, C_MAX}) begin
      count_d = C_MAX;
    end else begin
      count_d = w_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// quad_decoder: X4 quadrature decoder with index latch, illegal-transition detection
// and saturating error/spike statistics.
`default_nettype none

module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W,
  parameter int unsigned ERR_W   = DEF_ERR_W
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               A,
  input  logic               B,
  input  logic               Z,
  input  logic               SpikeA,
  input  logic               SpikeB,
  input  logic               Clear,
  output logic [COUNT_W-1:0] Count,
  output logic               Dir,
  output logic               Step,
  output logic               Illegal,
  output logic [COUNT_W-1:0] IndexPos,
  output logic               IndexSeen,
  output logic [ERR_W-1:0]   ErrCount,
  output logic [ERR_W-1:0]   SpikeCount
);

  localparam logic [COUNT_W-1:0] C_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             state_q;
  logic [1:0]         prev_ab_q;
  logic               prev_z_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] index_pos_q;
  logic               index_seen_q;
  logic               dir_q;
  logic               step_q;
  logic               illegal_q;

  logic [1:0]         w_ab;
  logic               w_run;
  logic               w_fwd;
  logic               w_rev;
  logic               w_illegal;
  logic               w_z_rise;
  logic [1:0]         w_err_inc;
  logic [1:0]         w_spike_inc;

  assign w_ab = {A, B};

  always_comb begin
    w_run     = (state_q == ST_RUN);
    w_fwd     = w_run && (w_ab == fwd_next(prev_ab_q));
    w_rev     = w_run && (w_ab == rev_next(prev_ab_q));
    w_illegal = w_run && ((w_ab ^ prev_ab_q) == 2'b11);
    w_z_rise  = w_run && !prev_z_q && Z;
    count_d   = count_q;
    if (w_fwd) begin
      count_d = count_q + C_ONE;
    end else if (w_rev) begin
      count_d = count_q - C_ONE;
    end
  end

  // Previous-sample registers load every cycle, including PRIME and Clear cycles.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= ST_PRIME;
      prev_ab_q    <= 2'b00;
      prev_z_q     <= 1'b0;
      count_q      <= '0;
      dir_q        <= 1'b1;
      step_q       <= 1'b0;
      illegal_q    <= 1'b0;
      index_pos_q  <= '0;
      index_seen_q <= 1'b0;
    end else begin
      state_q   <= ST_RUN;
      prev_ab_q <= w_ab;
      prev_z_q  <= Z;
      if (Clear) begin
        count_q      <= '0;
        step_q       <= 1'b0;
        illegal_q    <= 1'b0;
        index_pos_q  <= '0;
        index_seen_q <= 1'b0;
      end else begin
        count_q   <= count_d;
        step_q    <= w_fwd || w_rev;
        illegal_q <= w_illegal;
        if (w_fwd || w_rev) begin
          dir_q <= w_fwd;
        end
        if (w_z_rise) begin
          index_pos_q  <= count_d;
          index_seen_q <= 1'b1;
        end
      end
    end
  end

  assign w_err_inc   = {1'b0, w_illegal};
  assign w_spike_inc = {SpikeA & SpikeB, SpikeA ^ SpikeB};

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .clear_i (Clear),
    .inc_i   (w_err_inc),
    .count_o (ErrCount)
  );

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_spike_cnt (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .clear_i (Clear),
    .inc_i   (w_spike_inc),
    .count_o (SpikeCount)
  );

  assign Count     = count_q;
  assign Dir       = dir_q;
  assign Step      = step_q;
  assign Illegal   = illegal_q;
  assign IndexPos  = index_pos_q;
  assign IndexSeen = index_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed self-checking bench for quad_decoder with hand-computed expectations.
`default_nettype none

module tb_quad_decoder;

  logic        clk;
  logic        Rst_n;
  logic        A, B, Z;
  logic        SpikeA, SpikeB, Clear;
  logic [31:0] Count;
  logic        Dir, Step, Illegal;
  logic [31:0] IndexPos;
  logic        IndexSeen;
  logic [15:0] ErrCount, SpikeCount;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] ab_cur = 2'b00;

  quad_decoder #(
    .COUNT_W (32),
    .ERR_W   (16)
  ) dut (
    .Clk        (clk),
    .Rst_n      (Rst_n),
    .A          (A),
    .B          (B),
    .Z          (Z),
    .SpikeA     (SpikeA),
    .SpikeB     (SpikeB),
    .Clear      (Clear),
    .Count      (Count),
    .Dir        (Dir),
    .Step       (Step),
    .Illegal    (Illegal),
    .IndexPos   (IndexPos),
    .IndexSeen  (IndexSeen),
    .ErrCount   (ErrCount),
    .SpikeCount (SpikeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Apply AB on a falling edge, then return 1 time unit after the sampling edge.
  task automatic drive_ab(input logic [1:0] ab);
    @(negedge clk);
    A = ab[1];
    B = ab[0];
    ab_cur = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; A = 1'b0; B = 1'b0; Z = 1'b0;
    SpikeA = 1'b0; SpikeB = 1'b0; Clear = 1'b0; ab_cur = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (Count !== 32'd0) $display("FAIL reset_count got %0d want 0", Count); else n_pass++;
    n_checks++; if (Dir !== 1'b1) $display("FAIL reset_dir got %b want 1", Dir); else n_pass++;
    n_checks++; if ({Step, Illegal} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {Step, Illegal}); else n_pass++;
    n_checks++; if ({IndexPos, IndexSeen} !== 33'd0) $display("FAIL reset_index got %0d/%b want 0/0", IndexPos, IndexSeen); else n_pass++;
    n_checks++; if ({ErrCount, SpikeCount} !== 32'd0) $display("FAIL reset_stats got %0d/%0d want 0/0", ErrCount, SpikeCount); else n_pass++;
  endtask

  task automatic test_forward;
    logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    Rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({Step, Count} !== 33'd0) $display("FAIL fwd_prime got step=%b count=%0d want 0/0", Step, Count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive_ab(seq[i]);
      n_checks++;
      if (Step !== 1'b1 || Dir !== 1'b1 || Count !== 32'(i + 1))
        $display("FAIL fwd_step%0d got step=%b dir=%b count=%0d want 1/1/%0d", i, Step, Dir, Count, i + 1);
      else n_pass++;
    end
    n_checks++; if (ErrCount !== 16'd0) $display("FAIL fwd_err got %0d want 0", ErrCount); else n_pass++;
  endtask

  task automatic test_reverse;
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive_ab(seq[i]);
      n_checks++;
      if (Step !== 1'b1 || Dir !== 1'b0 || Count !== 32'(3 - i))
        $display("FAIL rev_step%0d got step=%b dir=%b count=%0d want 1/0/%0d", i, Step, Dir, Count, 3 - i);
      else n_pass++;
    end
    drive_ab(2'b01);
    n_checks++; if (Count !== 32'hFFFF_FFFF) $display("FAIL rev_wrap got %h want ffffffff", Count); else n_pass++;
  endtask

  task automatic test_illegal;
    drive_ab(2'b00);
    n_checks++; if (Count !== 32'd0 || Dir !== 1'b1) $display("FAIL ill_wrapup got %h/%b want 0/1", Count, Dir); else n_pass++;
    drive_ab(2'b11);
    n_checks++;
    if (Illegal !== 1'b1 || Step !== 1'b0 || ErrCount !== 16'd1 || Count !== 32'd0 || Dir !== 1'b1)
      $display("FAIL ill_detect got ill=%b step=%b err=%0d count=%0d dir=%b want 1/0/1/0/1", Illegal, Step, ErrCount, Count, Dir);
    else n_pass++;
    drive_ab(2'b11);
    n_checks++; if (Illegal !== 1'b0) $display("FAIL ill_oneshot got %b want 0", Illegal); else n_pass++;
    drive_ab(2'b01);
    n_checks++;
    if (Step !== 1'b1 || Count !== 32'd1 || Dir !== 1'b1)
      $display("FAIL ill_resync got step=%b count=%0d dir=%b want 1/1/1", Step, Count, Dir);
    else n_pass++;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 65533; i++) drive_ab(~ab_cur);
    n_checks++; if (ErrCount !== 16'd65534) $display("FAIL sat_pre got %0d want 65534", ErrCount); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_ab(~ab_cur);
      n_checks++;
      if (ErrCount !== 16'd65535 || Illegal !== 1'b1)
        $display("FAIL sat_hold%0d got err=%0d ill=%b want 65535/1", i, ErrCount, Illegal);
      else n_pass++;
    end
    n_checks++; if (Count !== 32'd1) $display("FAIL sat_count got %0d want 1", Count); else n_pass++;
    SpikeA = 1'b1; SpikeB = 1'b1;
    drive_ab(ab_cur);
    SpikeA = 1'b0; SpikeB = 1'b0;
    n_checks++; if (SpikeCount !== 16'd2) $display("FAIL spike_both got %0d want 2", SpikeCount); else n_pass++;
    SpikeA = 1'b1;
    drive_ab(ab_cur);
    SpikeA = 1'b0;
    n_checks++; if (SpikeCount !== 16'd3) $display("FAIL spike_one got %0d want 3", SpikeCount); else n_pass++;
  endtask

  task automatic test_index;
    logic [1:0] seq [7] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    Clear = 1'b1;
    drive_ab(ab_cur);
    Clear = 1'b0;
    n_checks++;
    if (Count !== 32'd0 || ErrCount !== 16'd0 || SpikeCount !== 16'd0 || IndexSeen !== 1'b0)
      $display("FAIL clr_all got count=%0d err=%0d spk=%0d seen=%b want 0/0/0/0", Count, ErrCount, SpikeCount, IndexSeen);
    else n_pass++;
    for (int i = 0; i < 7; i++) drive_ab(seq[i]);
    n_checks++; if (Count !== 32'd7) $display("FAIL idx_pre got %0d want 7", Count); else n_pass++;
    Z = 1'b1;
    drive_ab(2'b01);
    n_checks++;
    if (Count !== 32'd8 || IndexPos !== 32'd8 || IndexSeen !== 1'b1 || Step !== 1'b1)
      $display("FAIL idx_latch got count=%0d pos=%0d seen=%b step=%b want 8/8/1/1", Count, IndexPos, IndexSeen, Step);
    else n_pass++;
    drive_ab(2'b00);
    n_checks++;
    if (Count !== 32'd9 || IndexPos !== 32'd8)
      $display("FAIL idx_hold got count=%0d pos=%0d want 9/8", Count, IndexPos);
    else n_pass++;
    Clear = 1'b1;
    drive_ab(2'b10);
    Clear = 1'b0;
    Z = 1'b0;
    n_checks++;
    if (Count !== 32'd0 || Step !== 1'b0 || IndexPos !== 32'd0 || IndexSeen !== 1'b0)
      $display("FAIL clr_step got count=%0d step=%b pos=%0d seen=%b want 0/0/0/0", Count, Step, IndexPos, IndexSeen);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [1:0] seq [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 5; i++) drive_ab(seq[i]);
    n_checks++; if (Count !== 32'd5) $display("FAIL rmid_pre got %0d want 5", Count); else n_pass++;
    @(negedge clk);
    Rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (Count !== 32'd0 || Step !== 1'b0 || Dir !== 1'b1)
      $display("FAIL rmid_reset got count=%0d step=%b dir=%b want 0/0/1", Count, Step, Dir);
    else n_pass++;
    Rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (Count !== 32'd0 || Step !== 1'b0 || Illegal !== 1'b0)
      $display("FAIL rmid_prime got count=%0d step=%b ill=%b want 0/0/0", Count, Step, Illegal);
    else n_pass++;
    drive_ab(2'b01);
    n_checks++;
    if (Count !== 32'd1 || Step !== 1'b1)
      $display("FAIL rmid_first got count=%0d step=%b want 1/1", Count, Step);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_illegal();
    test_saturation();
    test_index();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter COUNT_W, default 32: position counter width in bits.
REQ-002 SHALL have parameter ERR_W, default 16: width of each saturating event counter.
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1  synchronous reset, active-low, sampled on posedge Clk.
REQ-005 A  input  1  filtered channel A (debouncer Qp output), already synchronous to Clk.
REQ-006 B  input  1  filtered channel B (debouncer Qp output), already synchronous to Clk.
REQ-007 Z  input  1  filtered index channel, synchronous to Clk.
REQ-008 SpikeA, SpikeB  input  1 each  one-cycle spike flags from the A/B debouncers.
REQ-009 Clear  input  1  synchronous clear of Count, IndexPos and all event counters.
REQ-010 Count  output  COUNT_W  signed position in quadrature edges (X4).
REQ-011 Dir  output  1  last valid direction: 1 = forward, 0 = reverse.
REQ-012 Step  output  1  one-cycle pulse on each valid count change.
REQ-013 Illegal  output  1  one-cycle pulse on each illegal AB transition.
REQ-014 IndexPos  output  COUNT_W  Count value latched at the last Z rising edge.
REQ-015 IndexSeen  output  1  sticky; set on first Z rising edge after reset or Clear.
REQ-016 ErrCount, SpikeCount  output  ERR_W each  saturating counts of illegal transitions and spikes.

Function
REQ-017 SHALL register {A,B} and Z each cycle as prevAB and prevZ; all decode SHALL compare the current input with the previous sample.
REQ-018 SHALL implement a two-state machine, PRIME -> RUN: PRIME loads prevAB/prevZ without counting, then moves to RUN on the next cycle.
REQ-019 In RUN, the forward {A,B} sequence 00->10->11->01->00 SHALL add +1 to Count, set Dir=1 and pulse Step.
REQ-020 The reverse sequence SHALL add -1 to Count, set Dir=0 and pulse Step.
REQ-021 Unchanged AB SHALL leave Count, Dir and Step unaffected (Step=0).
REQ-022 A change of both bits SHALL pulse Illegal, increment ErrCount and leave Count and Dir unchanged; prevAB SHALL still take the new value (resync).
REQ-023 Count, Dir, Step and Illegal SHALL update on the same posedge that samples the changed AB, giving 1-cycle latency from input to output.
REQ-024 Count SHALL wrap modulo 2^COUNT_W in both directions with no flag.
REQ-025 ErrCount and SpikeCount SHALL saturate at 2^ERR_W-1.
REQ-026 SpikeCount SHALL add 1 when exactly one of SpikeA/SpikeB is high and 2 when both are high, saturating at the limit.
REQ-027 A Z rising edge (prevZ=0, Z=1) in RUN SHALL load IndexPos with the post-update Count of that same cycle and set IndexSeen.
REQ-028 Clear SHALL zero Count, IndexPos, IndexSeen, ErrCount and SpikeCount and force Step=Illegal=0; it overrides any simultaneous step, spike or index event; prevAB/prevZ still load and the state stays RUN.

Reset
REQ-029 Rst_n=0 SHALL set Count=0, Dir=1, Step=0, Illegal=0, IndexPos=0, IndexSeen=0, ErrCount=0, SpikeCount=0 and state=PRIME.
REQ-030 Reset asserted mid-operation SHALL take effect on the next posedge, discarding any pending transition; the first cycle after release SHALL be PRIME, so no count results from the post-reset AB value.

Structure
REQ-031 A shared package SHALL hold the state enum (PRIME, RUN), the Gray constants for the forward successor of each AB value, and the default widths.
REQ-032 A single sub-module sat_counter (width parameter, inc amount 0..2, clear, saturate) SHALL be instantiated twice, for ErrCount and SpikeCount.

Verification
REQ-033 Release reset with AB=00, then drive 10,11,01,00 one per cycle -> Count=4, Dir=1, four Step pulses, ErrCount=0.
REQ-034 From Count=4, drive AB 01,11,10,00 -> Count=0, Dir=0; then drive one further reverse step -> Count=2^COUNT_W-1.
REQ-035 AB 00->11 in one cycle -> Illegal pulses once, ErrCount=1, Count unchanged; the following 11->01 step counts +1.
REQ-036 Force ErrCount to 65534, then apply three illegal transitions -> ErrCount holds 65535; SpikeA and SpikeB both high in one cycle -> SpikeCount +2.
REQ-037 Z rises on the same cycle as a forward step from Count=7 -> IndexPos=8 and IndexSeen=1; Clear asserted on the same cycle as a step -> Count=0 and Step=0.
REQ-038 Assert Rst_n=0 mid-sequence with AB=11, release with AB=11 -> no Step in the PRIME cycle, Count=0, and the next change 11->01 gives Count=1.
